// File: rtl/ecc_point_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ecc_point_ctrl
// Brief    : Sequencer for affine elliptic-curve point add / double. Issues
//            the GF(p) operation list one op at a time to an external
//            arithmetic unit and collects the results in a small register file.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_point_ctrl #(
    parameter int SIZE = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            start,
    input  logic            op_double,
    input  logic [SIZE-1:0] x1,
    input  logic [SIZE-1:0] y1,
    input  logic [SIZE-1:0] x2,
    input  logic [SIZE-1:0] y2,
    input  logic [SIZE-1:0] a,
    output logic [SIZE-1:0] x3,
    output logic [SIZE-1:0] y3,
    output logic            inf,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] gf_in_0,
    output logic [SIZE-1:0] gf_in_1,
    output logic [1:0]      gf_op,
    output logic            gf_start,
    input  logic [SIZE-1:0] gf_result,
    input  logic            gf_done
);

    // Arithmetic-unit opcodes
    localparam logic [1:0] c_ADD = 2'd0;
    localparam logic [1:0] c_SUB = 2'd1;
    localparam logic [1:0] c_MUL = 2'd2;
    localparam logic [1:0] c_DIV = 2'd3;

    // Register-file slots: captured operands, temporaries, lambda and result
    localparam logic [3:0] c_X1 = 4'd0;
    localparam logic [3:0] c_Y1 = 4'd1;
    localparam logic [3:0] c_X2 = 4'd2;
    localparam logic [3:0] c_Y2 = 4'd3;
    localparam logic [3:0] c_A  = 4'd4;
    localparam logic [3:0] c_T0 = 4'd5;
    localparam logic [3:0] c_T1 = 4'd6;
    localparam logic [3:0] c_T2 = 4'd7;
    localparam logic [3:0] c_T3 = 4'd8;
    localparam logic [3:0] c_T4 = 4'd9;
    localparam logic [3:0] c_T5 = 4'd10;
    localparam logic [3:0] c_L  = 4'd11;
    localparam logic [3:0] c_X  = 4'd12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      step_q;
    logic            dbl_q;
    logic            inf_q;
    logic [SIZE-1:0] x3_q, y3_q;
    logic [SIZE-1:0] rf_q [0:15];

    logic [1:0]      w_op;
    logic [3:0]      w_src0, w_src1, w_dst;
    logic            w_last;
    logic            w_exit;
    logic            w_same;

    // Microcode: {opcode, source 0, source 1, destination} per step
    function automatic logic [13:0] ucode(input logic dbl, input logic [3:0] step);
        logic [13:0] u;
        u = '0;
        case ({dbl, step})
            // P1 + P2
            5'h00: u = {c_SUB, c_Y2, c_Y1, c_T0};
            5'h01: u = {c_SUB, c_X2, c_X1, c_T1};
            5'h02: u = {c_DIV, c_T0, c_T1, c_L };
            5'h03: u = {c_MUL, c_L,  c_L,  c_T2};
            5'h04: u = {c_SUB, c_T2, c_X1, c_T3};
            5'h05: u = {c_SUB, c_T3, c_X2, c_X };
            5'h06: u = {c_SUB, c_X1, c_X,  c_T4};
            5'h07: u = {c_MUL, c_L,  c_T4, c_T5};
            5'h08: u = {c_SUB, c_T5, c_Y1, 4'd13};
            // 2 * P1
            5'h10: u = {c_MUL, c_X1, c_X1, c_T0};
            5'h11: u = {c_ADD, c_T0, c_T0, c_T1};
            5'h12: u = {c_ADD, c_T1, c_T0, c_T1};
            5'h13: u = {c_ADD, c_T1, c_A,  c_T1};
            5'h14: u = {c_ADD, c_Y1, c_Y1, c_T2};
            5'h15: u = {c_DIV, c_T1, c_T2, c_L };
            5'h16: u = {c_MUL, c_L,  c_L,  c_T2};
            5'h17: u = {c_SUB, c_T2, c_X1, c_T3};
            5'h18: u = {c_SUB, c_T3, c_X1, c_X };
            5'h19: u = {c_SUB, c_X1, c_X,  c_T4};
            5'h1a: u = {c_MUL, c_L,  c_T4, c_T5};
            5'h1b: u = {c_SUB, c_T5, c_Y1, 4'd13};
            default: u = '0;
        endcase
        return u;
    endfunction

    assign {w_op, w_src0, w_src1, w_dst} = ucode(dbl_q, step_q);
    assign w_last = (step_q == (dbl_q ? 4'd11 : 4'd8));
    assign w_same = (rf_q[c_X1] == rf_q[c_X2]);
    // Early exit: vertical chord (P + -P) or doubling a point with y = 0
    assign w_exit = dbl_q ? (rf_q[c_Y1] == '0)
                          : (w_same && (rf_q[c_Y1] != rf_q[c_Y2]));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; operands held through ISSUE and WAIT
    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        done     = 1'b0;
        gf_start = 1'b0;
        gf_op    = 2'd0;
        gf_in_0  = '0;
        gf_in_1  = '0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = CHECK;
            end
            CHECK: state_d = w_exit ? FIN : ISSUE;
            ISSUE: begin
                gf_start = 1'b1;
                gf_op    = w_op;
                gf_in_0  = rf_q[w_src0];
                gf_in_1  = rf_q[w_src1];
                state_d  = WAIT;
            end
            WAIT: begin
                gf_op   = w_op;
                gf_in_0 = rf_q[w_src0];
                gf_in_1 = rf_q[w_src1];
                if (gf_done) state_d = w_last ? FIN : ISSUE;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, result write-back and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            step_q <= '0;
            dbl_q  <= 1'b0;
            inf_q  <= 1'b0;
            x3_q   <= '0;
            y3_q   <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rf_q[c_X1] <= x1;
                        rf_q[c_Y1] <= y1;
                        rf_q[c_X2] <= x2;
                        rf_q[c_Y2] <= y2;
                        rf_q[c_A]  <= a;
                        dbl_q      <= op_double;
                        inf_q      <= 1'b0;
                        step_q     <= '0;
                    end
                end
                CHECK: begin
                    if (w_exit) begin
                        inf_q <= 1'b1;
                        x3_q  <= '0;
                        y3_q  <= '0;
                    end else if (!dbl_q && w_same) begin
                        // P + P falls back to the tangent (doubling) formula
                        dbl_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (gf_done) begin
                        rf_q[w_dst] <= gf_result;
                        step_q      <= step_q + 4'd1;
                        if (w_last) begin
                            // Last op produces Y; publish so it is valid with done
                            x3_q <= rf_q[c_X];
                            y3_q <= gf_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign x3  = x3_q;
    assign y3  = y3_q;
    assign inf = inf_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_point_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_point_ctrl
// Brief    : Directed bench for ecc_point_ctrl over GF(97), a = 2, with a
//            behavioural arithmetic unit that answers after 1-40 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_point_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        start, op_double;
    logic [31:0] x1, y1, x2, y2, a;
    logic [31:0] x3, y3, gf_in_0, gf_in_1, gf_result;
    logic        inf, busy, done, gf_start, gf_done;
    logic [1:0]  gf_op;

    int tests = 0;
    int fails = 0;
    int n_gfs = 0;
    int viol  = 0;

    ecc_point_ctrl #(.SIZE(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .start(start), .op_double(op_double),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .a(a),
        .x3(x3), .y3(y3), .inf(inf), .busy(busy), .done(done),
        .gf_in_0(gf_in_0), .gf_in_1(gf_in_1), .gf_op(gf_op),
        .gf_start(gf_start), .gf_result(gf_result), .gf_done(gf_done)
    );

    always #5 i_clk = ~i_clk;

    // GF(97) reference arithmetic
    function automatic logic [31:0] gf_calc(input logic [1:0] op, input logic [31:0] u, input logic [31:0] v);
        int r;
        case (op)
            2'd0: return (u + v) % 97;
            2'd1: return (u + 97 - v) % 97;
            2'd2: return (u * v) % 97;
            default: begin
                r = 1;
                for (int k = 0; k < 95; k++) r = (r * int'(v)) % 97;
                return (int'(u) * r) % 97;
            end
        endcase
    endfunction

    // Arithmetic-unit model; an in-flight op is dropped when reset is seen
    initial begin
        logic [31:0] res;
        int          lat;
        bit          abort;
        gf_done   = 1'b0;
        gf_result = '0;
        forever begin
            @(negedge i_clk);
            if (gf_start === 1'b1) begin
                res   = gf_calc(gf_op, gf_in_0, gf_in_1);
                lat   = $urandom_range(1, 40);
                abort = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge i_clk);
                    if (i_rst === 1'b1) abort = 1'b1;
                end
                if (!abort) begin
                    #1 gf_done = 1'b1;
                    gf_result  = res;
                    @(posedge i_clk);
                    #1 gf_done = 1'b0;
                end
            end
        end
    end

    // Launch-strobe count and strobes seen while the controller is idle
    always @(negedge i_clk) begin
        if (gf_start === 1'b1) n_gfs++;
        if (gf_start === 1'b1 && busy !== 1'b1) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic dbl, input logic [31:0] px1, input logic [31:0] py1,
                            input logic [31:0] px2, input logic [31:0] py2);
        @(negedge i_clk);
        op_double = dbl;
        x1 = px1; y1 = py1; x2 = px2; y2 = py2;
        start = 1'b1;
        @(negedge i_clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high; cyc counts cycles after CHECK
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("done_seen", {31'd0, done === 1'b1}, 32'd1);
    endtask

    initial begin
        int cyc, extra, nis;
        i_rst = 1'b1; start = 1'b0; op_double = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; a = 32'd2;
        repeat (3) @(negedge i_clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_inf", {31'd0, inf}, 0);
        chk("rst_gf_start", {31'd0, gf_start}, 0);
        chk("rst_gf_op", {30'd0, gf_op}, 0);
        chk("rst_gf_in_0", gf_in_0, 0);
        chk("rst_gf_in_1", gf_in_1, 0);
        chk("rst_x3", x3, 0);
        chk("rst_y3", y3, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // 2*(3,6) = (80,10)
        n_gfs = 0;
        start_op(1'b1, 3, 6, 0, 0);
        wait_done(cyc);
        chk("dbl_x3", x3, 80);
        chk("dbl_y3", y3, 10);
        chk("dbl_inf", {31'd0, inf}, 0);
        chk("dbl_ops", n_gfs, 12);
        @(negedge i_clk);
        chk("dbl_done_pulse", {31'd0, done}, 0);
        chk("dbl_idle", {31'd0, busy}, 0);
        chk("dbl_hold_y3", y3, 10);

        // (3,6)+(80,10) = (80,87)
        n_gfs = 0;
        start_op(1'b0, 3, 6, 80, 10);
        wait_done(cyc);
        chk("add_x3", x3, 80);
        chk("add_y3", y3, 87);
        chk("add_inf", {31'd0, inf}, 0);
        chk("add_ops", n_gfs, 9);

        // (3,6)+(3,91) = point at infinity, no arithmetic issued
        n_gfs = 0;
        start_op(1'b0, 3, 6, 3, 91);
        wait_done(cyc);
        chk("neg_latency", cyc + 1, 2);
        chk("neg_inf", {31'd0, inf}, 1);
        chk("neg_x3", x3, 0);
        chk("neg_y3", y3, 0);
        chk("neg_ops", n_gfs, 0);
        @(negedge i_clk);
        chk("neg_hold_inf", {31'd0, inf}, 1);

        // Second start while busy is ignored
        n_gfs = 0;
        start_op(1'b1, 3, 6, 0, 0);
        repeat (5) @(negedge i_clk);
        op_double = 1'b0; x1 = 3; y1 = 6; x2 = 80; y2 = 10;
        start = 1'b1;
        @(negedge i_clk);
        start = 1'b0;
        wait_done(cyc);
        chk("busy_x3", x3, 80);
        chk("busy_y3", y3, 10);
        chk("busy_ops", n_gfs, 12);
        extra = 0;
        repeat (60) begin
            @(negedge i_clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        chk("busy_extra_done", extra, 0);

        // (3,6)+(3,6) takes the doubling path
        n_gfs = 0;
        start_op(1'b0, 3, 6, 3, 6);
        wait_done(cyc);
        chk("same_x3", x3, 80);
        chk("same_y3", y3, 10);
        chk("same_inf", {31'd0, inf}, 0);
        chk("same_ops", n_gfs, 12);

        // Reset during WAIT of step 5, then a fresh add
        start_op(1'b1, 3, 6, 0, 0);
        nis = 0; cyc = 0;
        while (nis < 6 && cyc < 2000) begin
            @(negedge i_clk);
            cyc++;
            if (gf_start === 1'b1) nis++;
        end
        chk("rst6_reached", nis, 6);
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(negedge i_clk);
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_done", {31'd0, done}, 0);
        chk("mid_gf_start", {31'd0, gf_start}, 0);
        chk("mid_gf_op", {30'd0, gf_op}, 0);
        chk("mid_gf_in_0", gf_in_0, 0);
        chk("mid_gf_in_1", gf_in_1, 0);
        chk("mid_x3", x3, 0);
        chk("mid_y3", y3, 0);
        chk("mid_inf", {31'd0, inf}, 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        extra = 0;
        repeat (50) begin
            @(negedge i_clk);
            if (done === 1'b1) extra++;
        end
        chk("mid_no_done", extra, 0);
        n_gfs = 0;
        start_op(1'b0, 3, 6, 80, 10);
        wait_done(cyc);
        chk("post_x3", x3, 80);
        chk("post_y3", y3, 87);
        chk("post_ops", n_gfs, 9);

        chk("gf_start_idle", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
